// File: rtl/spi_reg_slave_if.sv
// Bundles the SPI pins and the internal register bus of spi_reg_slave.
// The slave modport is the design's view; the master modport is the view of
// whatever sits on the other side (host SPI master plus register file).
interface spi_reg_slave_if #(
    parameter int ADDR_WIDTH = 8,
    parameter int DATA_WIDTH = 16
);
    logic                  spi_clk;
    logic                  spi_csn;
    logic                  spi_mosi;
    logic                  spi_miso;
    logic                  reg_wr_en;
    logic                  reg_rd_en;
    logic [ADDR_WIDTH-1:0] reg_addr;
    logic [DATA_WIDTH-1:0] reg_wdata;
    logic [DATA_WIDTH-1:0] reg_rdata;
    logic                  frame_err;
    logic                  busy;

    modport slave (
        input  spi_clk, spi_csn, spi_mosi, reg_rdata,
        output spi_miso, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, frame_err, busy
    );

    modport master (
        output spi_clk, spi_csn, spi_mosi, reg_rdata,
        input  spi_miso, reg_wr_en, reg_rd_en, reg_addr, reg_wdata, frame_err, busy
    );
endinterface

// File: rtl/spi_reg_slave.sv
// SPI mode-0 register slave. SCK/CSN/MOSI are oversampled in the core clock
// domain; each frame {cmd, addr, pad, data} becomes a single-cycle register
// write or read strobe, and read data is shifted back out on MISO.
// ADDR_WIDTH, DATA_WIDTH and SYNC_STAGES are all expected to be >= 2.
module spi_reg_slave #(
    parameter int ADDR_WIDTH  = 8,
    parameter int DATA_WIDTH  = 16,
    parameter int SYNC_STAGES = 2
) (
    input  logic                  clk,
    input  logic                  rst_n,
    spi_reg_slave_if.slave        bus
);
    localparam int SH_W  = (ADDR_WIDTH > DATA_WIDTH) ? ADDR_WIDTH : DATA_WIDTH;
    localparam int CNT_W = $clog2(SH_W + 1);
    // Idle values of the synchronised pins, bit order {sck, csn, mosi}
    localparam logic [2:0] SYNC_RST = 3'b010;

    typedef enum logic [2:0] {IDLE, CMD, ADDR, PAD, DATA, DRAIN} state_t;

    logic [2:0] pin_vec;
    logic [2:0] sync_vec;
    logic       sck_s, csn_s, mosi_s;
    logic       sck_prev_reg, csn_prev_reg;
    logic       sck_rise, sck_fall, csn_fall, csn_rise;

    state_t                state_reg, state_next;
    logic [CNT_W-1:0]      bit_cnt_reg, bit_cnt_next;
    logic [1:0]            cmd_reg, cmd_next;
    logic [SH_W-1:0]       shift_reg, shift_next;
    logic [DATA_WIDTH-1:0] tx_shift_reg, tx_shift_next;
    logic                  rd_sample_reg, rd_sample_next;
    logic                  miso_reg, miso_next;
    logic                  wr_en_reg, wr_en_next;
    logic                  rd_en_reg, rd_en_next;
    logic                  err_reg, err_next;
    logic [ADDR_WIDTH-1:0] addr_reg, addr_next;
    logic [DATA_WIDTH-1:0] wdata_reg, wdata_next;

    logic [SH_W-1:0]       shift_in;
    logic [1:0]            cmd_in;
    logic                  cmd_is_wr, cmd_is_rd;

    assign pin_vec = {bus.spi_clk, bus.spi_csn, bus.spi_mosi};

    // One independent synchroniser chain per SPI input
    generate
        for (genvar gi = 0; gi < 3; gi++) begin : g_sync
            logic [SYNC_STAGES-1:0] chain_reg;

            // Shift the raw pin through SYNC_STAGES flops
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    chain_reg <= {SYNC_STAGES{SYNC_RST[gi]}};
                end else begin
                    chain_reg <= {chain_reg[SYNC_STAGES-2:0], pin_vec[gi]};
                end
            end

            assign sync_vec[gi] = chain_reg[SYNC_STAGES-1];
        end
    endgenerate

    assign sck_s  = sync_vec[2];
    assign csn_s  = sync_vec[1];
    assign mosi_s = sync_vec[0];

    // Remember the previous synchronised SCK/CSN for edge detection
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sck_prev_reg <= 1'b0;
            csn_prev_reg <= 1'b1;
        end else begin
            sck_prev_reg <= sck_s;
            csn_prev_reg <= csn_s;
        end
    end

    assign sck_rise = sck_s & ~sck_prev_reg;
    assign sck_fall = ~sck_s & sck_prev_reg;
    assign csn_fall = ~csn_s & csn_prev_reg;
    assign csn_rise = csn_s & ~csn_prev_reg;

    assign shift_in  = {shift_reg[SH_W-2:0], mosi_s};
    assign cmd_in    = {cmd_reg[0], mosi_s};
    assign cmd_is_wr = (cmd_reg == 2'b10);
    assign cmd_is_rd = (cmd_reg == 2'b01);

    // Frame state, datapath registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg     <= IDLE;
            bit_cnt_reg   <= '0;
            cmd_reg       <= '0;
            shift_reg     <= '0;
            tx_shift_reg  <= '0;
            rd_sample_reg <= 1'b0;
            miso_reg      <= 1'b0;
            wr_en_reg     <= 1'b0;
            rd_en_reg     <= 1'b0;
            err_reg       <= 1'b0;
            addr_reg      <= '0;
            wdata_reg     <= '0;
        end else begin
            state_reg     <= state_next;
            bit_cnt_reg   <= bit_cnt_next;
            cmd_reg       <= cmd_next;
            shift_reg     <= shift_next;
            tx_shift_reg  <= tx_shift_next;
            rd_sample_reg <= rd_sample_next;
            miso_reg      <= miso_next;
            wr_en_reg     <= wr_en_next;
            rd_en_reg     <= rd_en_next;
            err_reg       <= err_next;
            addr_reg      <= addr_next;
            wdata_reg     <= wdata_next;
        end
    end

    // Next-state logic: frame parsing, strobes, abort handling and MISO shifting
    always_comb begin
        state_next     = state_reg;
        bit_cnt_next   = bit_cnt_reg;
        cmd_next       = cmd_reg;
        shift_next     = shift_reg;
        tx_shift_next  = tx_shift_reg;
        miso_next      = miso_reg;
        addr_next      = addr_reg;
        wdata_next     = wdata_reg;
        wr_en_next     = 1'b0;
        rd_en_next     = 1'b0;
        err_next       = 1'b0;
        // Read data arrives one cycle after the read strobe
        rd_sample_next = rd_en_reg;
        if (rd_sample_reg) begin
            tx_shift_next = bus.reg_rdata;
        end

        if (state_reg == IDLE) begin
            if (csn_fall) begin
                state_next   = CMD;
                bit_cnt_next = '0;
                cmd_next     = 2'b00;
                miso_next    = 1'b0;
            end
        end else if (csn_rise) begin
            // CSN rise beats any same-cycle SCK edge; an unfinished frame or a
            // completed frame with a bad command is reported once
            state_next   = IDLE;
            bit_cnt_next = '0;
            miso_next    = 1'b0;
            err_next     = (state_reg != DRAIN) || !(cmd_is_wr || cmd_is_rd);
        end else begin
            case (state_reg)
                CMD: begin
                    if (sck_rise) begin
                        cmd_next = cmd_in;
                        if (bit_cnt_reg == CNT_W'(1)) begin
                            state_next   = ADDR;
                            bit_cnt_next = '0;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
                ADDR: begin
                    if (sck_rise) begin
                        shift_next = shift_in;
                        if (bit_cnt_reg == CNT_W'(ADDR_WIDTH - 1)) begin
                            state_next   = PAD;
                            bit_cnt_next = '0;
                            if (cmd_is_wr || cmd_is_rd) begin
                                addr_next = shift_in[ADDR_WIDTH-1:0];
                            end
                            rd_en_next = cmd_is_rd;
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end
                end
                PAD: begin
                    if (sck_rise) begin
                        state_next   = DATA;
                        bit_cnt_next = '0;
                    end
                end
                DATA: begin
                    if (sck_rise) begin
                        shift_next = shift_in;
                        if (bit_cnt_reg == CNT_W'(DATA_WIDTH - 1)) begin
                            state_next = DRAIN;
                            miso_next  = 1'b0;
                            if (cmd_is_wr) begin
                                wdata_next = shift_in[DATA_WIDTH-1:0];
                                wr_en_next = 1'b1;
                            end
                        end else begin
                            bit_cnt_next = bit_cnt_reg + 1'b1;
                        end
                    end else if (sck_fall && cmd_is_rd) begin
                        // The fall with no data bit yet captured ends the PAD bit
                        if (bit_cnt_reg == '0) begin
                            miso_next = tx_shift_reg[DATA_WIDTH-1];
                        end else begin
                            tx_shift_next = {tx_shift_reg[DATA_WIDTH-2:0], 1'b0};
                            miso_next     = tx_shift_reg[DATA_WIDTH-2];
                        end
                    end
                end
                default: begin
                    // DRAIN: surplus SCK edges are ignored until CSN rises
                end
            endcase
        end
    end

    assign bus.spi_miso  = miso_reg;
    assign bus.reg_wr_en = wr_en_reg;
    assign bus.reg_rd_en = rd_en_reg;
    assign bus.reg_addr  = addr_reg;
    assign bus.reg_wdata = wdata_reg;
    assign bus.frame_err = err_reg;
    assign bus.busy      = ~csn_s;
endmodule

// File: tb/tb_spi_reg_slave.sv
// Bench for spi_reg_slave: a host task bit-bangs SPI frames, a small register
// file answers the register bus, and a scoreboard compares every strobe and
// error pulse against events predicted from the frame contents.
module tb_spi_reg_slave;
    localparam int AW = 8;
    localparam int DW = 16;
    localparam int HP = 5;   // SPI half period in core clocks

    typedef struct {
        int          kind;   // 0 write, 1 read, 2 frame error
        logic [7:0]  addr;
        logic [15:0] data;
    } ev_t;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;
    ev_t  exp_q[$];

    logic [15:0] rf [256];      // register file seen by the DUT
    logic [15:0] model [256];   // reference contents predicted by the bench
    logic [7:0]  last_addr;     // predicted reg_addr

    spi_reg_slave_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

    spi_reg_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .SYNC_STAGES(2)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [15:0] init_val(input int i);
        logic [7:0] b;
        b = 8'(i);
        return (i == 18) ? 16'hBEEF : {b, ~b};
    endfunction

    // Register file: reset to a known pattern, registered read
    always @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < 256; i++) rf[i] <= init_val(i);
            bus.reg_rdata <= 16'h0;
        end else begin
            if (bus.reg_wr_en) rf[bus.reg_addr] <= bus.reg_wdata;
            if (bus.reg_rd_en) bus.reg_rdata <= rf[bus.reg_addr];
        end
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%h required=%h", name, act, req);
        end
    endtask

    task automatic sb_pop(input int kind, input logic [7:0] a, input logic [15:0] d);
        ev_t e;
        checks++;
        if (exp_q.size() == 0) begin
            errors++;
            $display("FAIL unexpected_event actual kind=%0d addr=%h data=%h required none", kind, a, d);
        end else begin
            e = exp_q.pop_front();
            if (e.kind != kind || (kind != 2 && e.addr != a) || (kind == 0 && e.data != d)) begin
                errors++;
                $display("FAIL scoreboard actual kind=%0d addr=%h data=%h required kind=%0d addr=%h data=%h",
                         kind, a, d, e.kind, e.addr, e.data);
            end else begin
                $display("event kind=%0d addr=%h data=%h ok", kind, a, d);
            end
        end
    endtask

    // Monitor: every strobe or error pulse must match the next predicted event
    always @(negedge clk) begin
        if (rst_n) begin
            if (bus.reg_wr_en) sb_pop(0, bus.reg_addr, bus.reg_wdata);
            if (bus.reg_rd_en) sb_pop(1, bus.reg_addr, 16'h0);
            if (bus.frame_err) sb_pop(2, 8'h0, 16'h0);
        end
    end

    task automatic push_ev(input int kind, input logic [7:0] a, input logic [15:0] d);
        ev_t e;
        e.kind = kind;
        e.addr = a;
        e.data = d;
        exp_q.push_back(e);
    endtask

    // Host side of one frame; called on a negedge, returns on a negedge
    task automatic run_frame(input logic [1:0] cmd, input logic [7:0] a, input logic [15:0] d,
                             input int nbits, input bit raise_csn, input int gap,
                             output logic [15:0] rx);
        logic [26:0] fr;
        fr = {cmd, a, 1'b0, d};
        rx = 16'h0;
        bus.spi_csn = 1'b0;
        repeat (HP) @(negedge clk);
        for (int i = 0; i < nbits; i++) begin
            bus.spi_mosi = fr[26-i];
            repeat (HP) @(negedge clk);
            bus.spi_clk = 1'b1;
            if (i >= 11) rx = {rx[14:0], bus.spi_miso};
            repeat (HP) @(negedge clk);
            bus.spi_clk = 1'b0;
        end
        if (raise_csn) begin
            repeat (HP) @(negedge clk);
            bus.spi_csn  = 1'b1;
            bus.spi_mosi = 1'b0;
            repeat (gap) @(negedge clk);
        end
    endtask

    // Full frame: predict the events and MISO word, run it, check host-side results
    task automatic do_frame(input logic [1:0] cmd, input logic [7:0] a, input logic [15:0] d, input int gap);
        logic [15:0] rx;
        logic [15:0] exp_rx;
        exp_rx = 16'h0;
        if (cmd == 2'b10) begin
            push_ev(0, a, d);
            model[a]  = d;
            last_addr = a;
        end else if (cmd == 2'b01) begin
            push_ev(1, a, 16'h0);
            exp_rx    = model[a];
            last_addr = a;
        end else begin
            push_ev(2, 8'h0, 16'h0);
        end
        run_frame(cmd, a, d, 27, 1'b1, gap, rx);
        $display("frame cmd=%b addr=%h data=%h miso=%h", cmd, a, d, rx);
        check("miso_word", 32'(rx), 32'(exp_rx));
        check("reg_addr_hold", 32'(bus.reg_addr), 32'(last_addr));
    endtask

    task automatic check_outputs_zero(input string tag);
        check({tag, "_wr_en"}, 32'(bus.reg_wr_en), 32'h0);
        check({tag, "_rd_en"}, 32'(bus.reg_rd_en), 32'h0);
        check({tag, "_frame_err"}, 32'(bus.frame_err), 32'h0);
        check({tag, "_busy"}, 32'(bus.busy), 32'h0);
        check({tag, "_miso"}, 32'(bus.spi_miso), 32'h0);
        check({tag, "_addr"}, 32'(bus.reg_addr), 32'h0);
        check({tag, "_wdata"}, 32'(bus.reg_wdata), 32'h0);
    endtask

    task automatic model_reset();
        for (int i = 0; i < 256; i++) model[i] = init_val(i);
        last_addr = 8'h0;
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog actual=timeout required=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [15:0] rx;
        int r;
        logic [1:0] cmd;
        checks       = 0;
        errors       = 0;
        rst_n        = 1'b0;
        bus.spi_clk  = 1'b0;
        bus.spi_csn  = 1'b1;
        bus.spi_mosi = 1'b0;
        model_reset();
        repeat (4) @(negedge clk);
        check_outputs_zero("reset");
        rst_n = 1'b1;
        repeat (3) @(negedge clk);

        // Directed frames
        do_frame(2'b10, 8'h05, 16'hA5C3, 3);
        do_frame(2'b01, 8'h12, 16'h0000, 3);
        do_frame(2'b11, 8'h05, 16'h1234, 3);

        // Abort after 12 bits of a write: address already latched, no write
        push_ev(2, 8'h0, 16'h0);
        last_addr = 8'h07;
        run_frame(2'b10, 8'h07, 16'hFFFF, 12, 1'b1, 2, rx);
        repeat (6) @(negedge clk);
        check("abort_busy", 32'(bus.busy), 32'h0);
        check("abort_addr", 32'(bus.reg_addr), 32'h07);
        do_frame(2'b10, 8'h01, 16'h0001, 3);

        // Reset in the middle of the DATA phase
        run_frame(2'b10, 8'h03, 16'h0001, 20, 1'b0, 0, rx);
        check("midframe_busy", 32'(bus.busy), 32'h1);
        rst_n = 1'b0;
        #1;
        check_outputs_zero("async_reset");
        bus.spi_csn  = 1'b1;
        bus.spi_clk  = 1'b0;
        bus.spi_mosi = 1'b0;
        model_reset();
        @(negedge clk);
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        repeat (3) @(negedge clk);
        do_frame(2'b10, 8'h00, 16'h0001, 3);

        // Back-to-back writes with a single clock of CSN high
        do_frame(2'b10, 8'h00, 16'h0001, 1);
        do_frame(2'b10, 8'h00, 16'h0002, 3);
        do_frame(2'b01, 8'h00, 16'h0000, 3);

        // Randomised frames over a small address window
        for (int n = 0; n < 24; n++) begin
            r = $urandom_range(0, 9);
            if (r < 4)      cmd = 2'b10;
            else if (r < 8) cmd = 2'b01;
            else if (r == 8) cmd = 2'b00;
            else            cmd = 2'b11;
            do_frame(cmd, 8'($urandom_range(0, 15)), 16'($urandom), $urandom_range(1, 4));
        end

        repeat (20) @(negedge clk);
        check("events_outstanding", 32'(exp_q.size()), 32'h0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
